// File: rtl/i2s_stream_player.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2s_stream_player: ROM-fed stereo sample player with Philips I2S output  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module i2s_stream_player #(
   parameter int WIDTH    = 16,
   parameter int ADDR_W   = 18,
   parameter int SCLK_DIV = 19,
   parameter int CNT_W    = 8
) (
   input  logic                 MCLK,
   input  logic                 nReset,
   input  logic                 start,
   input  logic                 stop,
   input  logic [CNT_W-1:0]     loop_count,
   input  logic [ADDR_W-1:0]    depth,
   input  logic [3:0]           vol_shift_l,
   input  logic [3:0]           vol_shift_r,
   input  logic                 mono,
   output logic [ADDR_W-1:0]    rom_addr,
   input  logic [2*WIDTH-1:0]   rom_data,
   output logic                 busy,
   output logic                 theme_ended,
   output logic [CNT_W-1:0]     play_count,
   output logic                 LRCLK,
   output logic                 SCLK,
   output logic                 SD
);

   localparam int FW    = 2 * WIDTH;
   localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam int POS_W = $clog2(FW);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_CAPTURE   = 3'd2,
      S_WAIT_TAKE = 3'd3,
      S_ADVANCE   = 3'd4
   } state_t;

   // Arithmetic attenuation; shifting a full slot or more yields silence, not -1.
   function automatic logic [WIDTH-1:0] scale(input logic [WIDTH-1:0] s, input logic [3:0] sh);
      logic signed [WIDTH-1:0] v;
      v = $signed(s) >>> sh;
      if (int'(sh) >= WIDTH) scale = '0;
      else scale = v;
   endfunction

   // ---------------- serializer ----------------
   logic [DIV_W-1:0] div_q, div_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic [FW-1:0]    shreg_q, shreg_d;
   logic             sclk_q, sclk_d;
   logic             lrclk_q, lrclk_d;
   logic             sd_q, sd_d;
   logic             div_wrap, sclk_fall, frame_take;
   logic [FW-1:0]    hold_q, hold_d;

   always_comb begin
      div_wrap   = (div_q == DIV_W'(SCLK_DIV - 1));
      div_d      = div_wrap ? '0 : div_q + 1'b1;
      sclk_d     = div_wrap ? ~sclk_q : sclk_q;
      sclk_fall  = div_wrap && sclk_q;
      frame_take = sclk_fall && (pos_q == '0);
      pos_d      = pos_q;
      lrclk_d    = lrclk_q;
      sd_d       = sd_q;
      shreg_d    = shreg_q;
      if (sclk_fall) begin
         pos_d   = (pos_q == POS_W'(FW - 1)) ? '0 : pos_q + 1'b1;
         // LRCLK leads each channel MSB by one bit slot
         lrclk_d = (pos_q >= POS_W'(WIDTH - 1)) && (pos_q != POS_W'(FW - 1));
         if (frame_take) begin
            sd_d    = hold_q[FW-1];
            shreg_d = {hold_q[FW-2:0], 1'b0};
         end else begin
            sd_d    = shreg_q[FW-1];
            shreg_d = {shreg_q[FW-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge MCLK or negedge nReset) begin
      if (!nReset) begin
         div_q   <= '0;
         pos_q   <= '0;
         shreg_q <= '0;
         sclk_q  <= 1'b0;
         lrclk_q <= 1'b0;
         sd_q    <= 1'b0;
      end else begin
         div_q   <= div_d;
         pos_q   <= pos_d;
         shreg_q <= shreg_d;
         sclk_q  <= sclk_d;
         lrclk_q <= lrclk_d;
         sd_q    <= sd_d;
      end
   end

   // ---------------- controller ----------------
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [ADDR_W-1:0] depth_q, depth_d;
   logic [CNT_W-1:0]  loop_q, loop_d;
   logic [CNT_W-1:0]  play_count_q, play_count_d;
   logic [CNT_W-1:0]  pc_inc;
   logic              last_word;

   always_comb begin
      state_d      = state_q;
      rom_addr_d   = rom_addr_q;
      depth_d      = depth_q;
      loop_d       = loop_q;
      play_count_d = play_count_q;
      hold_d       = hold_q;
      last_word    = (rom_addr_q == depth_q - 1'b1);
      pc_inc       = (play_count_q == '1) ? play_count_q : play_count_q + 1'b1;
      case (state_q)
         S_IDLE: begin
            if (start && (depth != '0)) begin
               depth_d      = depth;
               loop_d       = loop_count;
               rom_addr_d   = '0;
               play_count_d = '0;
               state_d      = S_FETCH;
            end
         end
         S_FETCH:   state_d = S_CAPTURE;
         S_CAPTURE: begin
            if (mono) hold_d = {scale(rom_data[FW-1:WIDTH], vol_shift_l),
                                scale(rom_data[FW-1:WIDTH], vol_shift_l)};
            else      hold_d = {scale(rom_data[FW-1:WIDTH], vol_shift_l),
                                scale(rom_data[WIDTH-1:0], vol_shift_r)};
            state_d = S_WAIT_TAKE;
         end
         S_WAIT_TAKE: if (frame_take) state_d = S_ADVANCE;
         S_ADVANCE: begin
            if (!last_word) begin
               rom_addr_d = rom_addr_q + 1'b1;
               state_d    = S_FETCH;
            end else begin
               play_count_d = pc_inc;
               rom_addr_d   = '0;
               if ((loop_q == '0) || (pc_inc < loop_q)) begin
                  state_d = S_FETCH;
               end else begin
                  hold_d  = '0;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (stop) begin
         state_d    = S_IDLE;
         hold_d     = '0;
         rom_addr_d = '0;
      end
   end

   always_ff @(posedge MCLK or negedge nReset) begin
      if (!nReset) begin
         state_q      <= S_IDLE;
         rom_addr_q   <= '0;
         depth_q      <= '0;
         loop_q       <= '0;
         play_count_q <= '0;
         hold_q       <= '0;
      end else begin
         state_q      <= state_d;
         rom_addr_q   <= rom_addr_d;
         depth_q      <= depth_d;
         loop_q       <= loop_d;
         play_count_q <= play_count_d;
         hold_q       <= hold_d;
      end
   end

   assign rom_addr    = rom_addr_q;
   assign busy        = (state_q != S_IDLE);
   assign theme_ended = (state_q == S_CAPTURE) && last_word;
   assign play_count  = play_count_q;
   assign LRCLK       = lrclk_q;
   assign SCLK        = sclk_q;
   assign SD          = sd_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_stream_player.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_i2s_stream_player: frame-level scoreboard bench for i2s_stream_player |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_i2s_stream_player;

   localparam int W      = 16;
   localparam int AW     = 18;
   localparam int CW     = 8;
   localparam int TMO    = 1200;

   logic          MCLK = 1'b0;
   logic          nReset = 1'b0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic [CW-1:0] loop_count = '0;
   logic [AW-1:0] depth = '0;
   logic [3:0]    vol_shift_l = '0;
   logic [3:0]    vol_shift_r = '0;
   logic          mono = 1'b0;
   logic [AW-1:0] rom_addr;
   logic [2*W-1:0] rom_data = '0;
   logic          busy, theme_ended, LRCLK, SCLK, SD;
   logic [CW-1:0] play_count;

   i2s_stream_player #(.WIDTH(W), .ADDR_W(AW), .SCLK_DIV(4), .CNT_W(CW)) dut (
      .MCLK(MCLK), .nReset(nReset), .start(start), .stop(stop),
      .loop_count(loop_count), .depth(depth),
      .vol_shift_l(vol_shift_l), .vol_shift_r(vol_shift_r), .mono(mono),
      .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy),
      .theme_ended(theme_ended), .play_count(play_count),
      .LRCLK(LRCLK), .SCLK(SCLK), .SD(SD)
   );

   always #5 MCLK = ~MCLK;

   // sample ROM model
   int rom_mode = 0;
   function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
      case (rom_mode)
         0:       return {a[15:0], ~a[15:0]};
         1:       return 32'h8000_7FFF;
         default: return 32'h1234_5678;
      endcase
   endfunction
   always @(posedge MCLK) rom_data <= rom_word(rom_addr);

   // I2S receiver: a LRCLK change seen at an SCLK rise marks the LSB of the old channel
   logic [31:0]  rx_q[$];
   logic [31:0]  exp_q[$];
   logic         sclk_p = 1'b0, lr_seen = 1'b0;
   logic [W-1:0] sr = '0, left_w = '0;
   int           te_cnt = 0;

   always @(negedge MCLK) begin
      sclk_p <= SCLK;
      if (!nReset) begin
         lr_seen <= 1'b0;
         sr      <= '0;
         left_w  <= '0;
         te_cnt  <= 0;
      end else begin
         if (theme_ended) te_cnt <= te_cnt + 1;
         if (SCLK && !sclk_p) begin
            sr <= {sr[W-2:0], SD};
            if (LRCLK != lr_seen) begin
               lr_seen <= LRCLK;
               if (!lr_seen) left_w <= {sr[W-2:0], SD};
               else rx_q.push_back({left_w, sr[W-2:0], SD});
            end
         end
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic get_frame(output logic [31:0] f, output bit ok);
      ok = 1'b0;
      f  = '0;
      for (int i = 0; i < TMO; i++) begin
         if (rx_q.size() > 0) begin
            f  = rx_q.pop_front();
            ok = 1'b1;
            return;
         end
         @(negedge MCLK);
      end
   endtask

   // pops every queued expectation against received frames; sync drops leading silence
   task automatic run_expect(input string name, input bit sync);
      logic [31:0] e, f;
      bit ok;
      int skips;
      bit first;
      first = 1'b1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         get_frame(f, ok);
         skips = 0;
         while (sync && first && ok && f == '0 && skips < 4) begin
            get_frame(f, ok);
            skips++;
         end
         first = 1'b0;
         if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: frame timeout, got none expected %h", name, e);
            exp_q.delete();
            return;
         end
         check(name, {32'd0, f}, {32'd0, e});
      end
   endtask

   task automatic pulse(input bit s, input bit p);
      @(negedge MCLK);
      start = s;
      stop  = p;
      @(negedge MCLK);
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20 * TMO && busy; i++) @(negedge MCLK);
      check("idle_timeout", {63'd0, busy}, 64'd0);
   endtask

   function automatic logic [31:0] word0(input int i);
      logic [15:0] v;
      v = 16'(i);
      return {v, ~v};
   endfunction

   typedef struct {
      int          mode;
      logic [3:0]  shl;
      logic [3:0]  shr;
      logic        mn;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[8];

   int te_base;

   initial begin
      vecs[0] = '{1, 4'd3,  4'd15, 1'b0, 32'hF000_0000};
      vecs[1] = '{2, 4'd1,  4'd9,  1'b1, 32'h091A_091A};
      vecs[2] = '{1, 4'd0,  4'd0,  1'b0, 32'h8000_7FFF};
      vecs[3] = '{1, 4'd15, 4'd15, 1'b0, 32'hFFFF_0000};
      vecs[4] = '{1, 4'd4,  4'd0,  1'b1, 32'hF800_F800};
      vecs[5] = '{2, 4'd4,  4'd8,  1'b0, 32'h0123_0056};
      vecs[6] = '{0, 4'd0,  4'd0,  1'b0, 32'h0000_FFFF};
      vecs[7] = '{0, 4'd0,  4'd15, 1'b0, 32'h0000_FFFF};

      repeat (3) @(negedge MCLK);
      check("reset_pins", {59'd0, SCLK, LRCLK, SD, busy, theme_ended}, 64'd0);
      check("reset_counts", {38'd0, play_count, rom_addr}, 64'd0);
      nReset = 1'b1;

      // play-once of a 4-word theme
      rom_mode = 0; depth = 4; loop_count = 1;
      te_base = te_cnt;
      rx_q.delete();
      pulse(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) exp_q.push_back(word0(i));
      exp_q.push_back('0);
      exp_q.push_back('0);
      run_expect("once_frames", 1'b1);
      check("once_busy", {63'd0, busy}, 64'd0);
      check("once_play_count", {56'd0, play_count}, 64'd1);
      check("once_theme_ended", 64'(te_cnt - te_base), 64'd1);

      // endless loop of a 3-word theme
      depth = 3; loop_count = 0;
      te_base = te_cnt;
      rx_q.delete();
      pulse(1'b1, 1'b0);
      for (int i = 0; i < 9; i++) exp_q.push_back(word0(i % 3));
      run_expect("loop_frames", 1'b1);
      check("loop_theme_ended", 64'(te_cnt - te_base), 64'd3);
      check("loop_play_count", {56'd0, play_count}, 64'd3);
      exp_q.push_back(word0(0));
      run_expect("loop_frame10", 1'b0);
      check("loop_busy", {63'd0, busy}, 64'd1);
      pulse(1'b0, 1'b1);
      wait_idle();
      repeat (600) @(negedge MCLK);

      // scaling / mono table, one word per vector
      depth = 1; loop_count = 1;
      foreach (vecs[k]) begin
         rom_mode    = vecs[k].mode;
         vol_shift_l = vecs[k].shl;
         vol_shift_r = vecs[k].shr;
         mono        = vecs[k].mn;
         rx_q.delete();
         pulse(1'b1, 1'b0);
         exp_q.push_back(vecs[k].exp);
         exp_q.push_back('0);
         run_expect($sformatf("scale_vec%0d", k), 1'b1);
         check($sformatf("scale_busy%0d", k), {63'd0, busy}, 64'd0);
      end
      vol_shift_l = '0; vol_shift_r = '0; mono = 1'b0;

      // stop in the middle of the third frame
      rom_mode = 0; depth = 8; loop_count = 0;
      rx_q.delete();
      pulse(1'b1, 1'b0);
      exp_q.push_back(word0(0));
      exp_q.push_back(word0(1));
      run_expect("stop_pre", 1'b1);
      repeat (60) @(negedge MCLK);
      pulse(1'b0, 1'b1);
      check("stop_busy", {63'd0, busy}, 64'd0);
      check("stop_rom_addr", {46'd0, rom_addr}, 64'd0);
      exp_q.push_back(word0(2));
      exp_q.push_back('0);
      run_expect("stop_post", 1'b0);

      pulse(1'b1, 1'b1);
      repeat (4) @(negedge MCLK);
      check("start_stop_same", {63'd0, busy}, 64'd0);

      // asynchronous reset during playback, then a zero-depth start
      rx_q.delete();
      pulse(1'b1, 1'b0);
      repeat (300) @(negedge MCLK);
      #2 nReset = 1'b0;
      #1;
      check("areset_pins", {59'd0, SCLK, LRCLK, SD, busy, theme_ended}, 64'd0);
      check("areset_counts", {38'd0, play_count, rom_addr}, 64'd0);
      repeat (3) @(negedge MCLK);
      nReset = 1'b1;
      rx_q.delete();
      depth = 0;
      pulse(1'b1, 1'b0);
      repeat (5) @(negedge MCLK);
      check("depth0_busy", {63'd0, busy}, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
